// File: rtl/move_pkg.sv
// Shared encodings and rate helper for the movement-pulse generator.
package move_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_BTN  = 2'b01;
    localparam logic [1:0] MODE_TILT = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_e;

    typedef enum logic {
        SRC_BTN  = 1'b0,
        SRC_TILT = 1'b1
    } src_e;

    // Rounded phase increment: rate * 2^acc_w / den.
    function automatic logic [63:0] rate_inc(
        input logic [63:0] rate,
        input int          acc_w,
        input logic [63:0] den
    );
        logic [63:0] num;
        num = rate << acc_w;
        return (num + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/move_axis.sv
// One axis: request resolution, direction/source state,
// phase accumulator and registered step pulses.
module move_axis
    import move_pkg::*;
#(
    parameter int               MAG_W     = 8,
    parameter int               ACC_W     = 32,
    parameter int               DEADZONE  = 16,
    parameter logic [ACC_W-1:0] BTN_INC   = '0,
    parameter logic [ACC_W-1:0] TILT_STEP = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             btn_pos,
    input  logic             btn_neg,
    input  logic             tilt_sign,
    input  logic [MAG_W-1:0] tilt_mag,
    output logic             move_pos,
    output logic             move_neg,
    output logic             axis_active
);

    localparam int               PROD_W  = ACC_W + MAG_W;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [MAG_W-1:0] DZ      = MAG_W'(DEADZONE);

    dir_e dir_q, dir_d, req_dir, btn_dir, tilt_dir;
    src_e src_q, src_d, req_src;

    logic [ACC_W-1:0]  acc_q, acc_d, inc, tilt_inc;
    logic [PROD_W-1:0] tilt_prod;
    logic [ACC_W:0]    sum;
    logic              btn_req, tilt_req;
    logic              pos_d, neg_d;

    assign btn_req  = btn_pos ^ btn_neg;
    assign tilt_req = tilt_mag > DZ;
    assign btn_dir  = btn_pos ? DIR_POS : DIR_NEG;
    assign tilt_dir = tilt_sign ? DIR_POS : DIR_NEG;

    assign tilt_prod = PROD_W'(tilt_mag - DZ) * PROD_W'(TILT_STEP);
    assign tilt_inc  = (|tilt_prod[PROD_W-1:ACC_W]) ? ACC_MAX
                                                    : tilt_prod[ACC_W-1:0];

    always_comb begin
        req_dir = DIR_IDLE;
        req_src = SRC_BTN;
        unique case (1'b1)
            (mode == MODE_OFF): begin
                req_dir = DIR_IDLE;
            end
            (mode == MODE_BTN): begin
                if (btn_req) req_dir = btn_dir;
            end
            (mode == MODE_TILT): begin
                if (tilt_req) begin
                    req_dir = tilt_dir;
                    req_src = SRC_TILT;
                end
            end
            (mode == MODE_BOTH): begin
                if (btn_req) begin
                    req_dir = btn_dir;
                end else if (tilt_req) begin
                    req_dir = tilt_dir;
                    req_src = SRC_TILT;
                end
            end
        endcase
    end

    assign inc = (req_src == SRC_BTN) ? BTN_INC : tilt_inc;

    always_comb begin
        dir_d = req_dir;
        src_d = req_src;
        acc_d = '0;
        pos_d = 1'b0;
        neg_d = 1'b0;
        sum   = {1'b0, acc_q} + {1'b0, inc};
        if (req_dir == DIR_IDLE) begin
            src_d = src_q;
        end else if (dir_q != req_dir || src_q != req_src) begin
            // New activation: immediate step, phase restarts.
            pos_d = (req_dir == DIR_POS);
            neg_d = (req_dir == DIR_NEG);
        end else begin
            acc_d = sum[ACC_W-1:0];
            pos_d = sum[ACC_W] & (dir_q == DIR_POS);
            neg_d = sum[ACC_W] & (dir_q == DIR_NEG);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q    <= DIR_IDLE;
            src_q    <= SRC_BTN;
            acc_q    <= '0;
            move_pos <= 1'b0;
            move_neg <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            src_q    <= src_d;
            acc_q    <= acc_d;
            move_pos <= pos_d;
            move_neg <= neg_d;
        end
    end

    assign axis_active = (dir_q != DIR_IDLE);

endmodule

// File: rtl/move_pulse_gen.sv
// Movement-pulse generator: buttons and accelerometer tilt
// turned into per-axis single-cycle step pulses.
module move_pulse_gen
    import move_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int NUM_AXES    = 2,
    parameter int MAG_W       = 8,
    parameter int DEADZONE    = 16,
    parameter int BTN_RATE_HZ = 90,
    parameter int MAX_RATE_HZ = 120,
    parameter int ACC_W       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic [NUM_AXES-1:0]       btn_pos,
    input  logic [NUM_AXES-1:0]       btn_neg,
    input  logic [NUM_AXES-1:0]       tilt_sign,
    input  logic [NUM_AXES*MAG_W-1:0] tilt_mag,
    output logic [NUM_AXES-1:0]       move_pos,
    output logic [NUM_AXES-1:0]       move_neg,
    output logic [NUM_AXES-1:0]       axis_active
);

    localparam int TILT_SPAN = (1 << MAG_W) - 1 - DEADZONE;

    localparam logic [63:0] BTN_INC_W =
        rate_inc(64'(BTN_RATE_HZ), ACC_W, 64'(CLK_HZ));
    localparam logic [63:0] TILT_STEP_W =
        rate_inc(64'(MAX_RATE_HZ), ACC_W, 64'(CLK_HZ) * 64'(TILT_SPAN));

    localparam logic [ACC_W-1:0] BTN_INC   = BTN_INC_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] TILT_STEP = TILT_STEP_W[ACC_W-1:0];

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        move_axis #(
            .MAG_W    (MAG_W),
            .ACC_W    (ACC_W),
            .DEADZONE (DEADZONE),
            .BTN_INC  (BTN_INC),
            .TILT_STEP(TILT_STEP)
        ) u_axis (
            .clk        (clk),
            .reset      (reset),
            .mode       (mode),
            .btn_pos    (btn_pos[i]),
            .btn_neg    (btn_neg[i]),
            .tilt_sign  (tilt_sign[i]),
            .tilt_mag   (tilt_mag[i*MAG_W +: MAG_W]),
            .move_pos   (move_pos[i]),
            .move_neg   (move_neg[i]),
            .axis_active(axis_active[i])
        );
    end

endmodule

// File: tb/tb_move_pulse_gen.sv
// Directed bench for move_pulse_gen at a 1 kHz clock with
// hand-computed pulse spacings.
module tb_move_pulse_gen;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic [1:0]  btn_pos;
    logic [1:0]  btn_neg;
    logic [1:0]  tilt_sign;
    logic [15:0] tilt_mag;
    logic [1:0]  move_pos;
    logic [1:0]  move_neg;
    logic [1:0]  axis_active;

    move_pulse_gen #(
        .CLK_HZ     (1000),
        .NUM_AXES   (2),
        .MAG_W      (8),
        .DEADZONE   (16),
        .BTN_RATE_HZ(100),
        .MAX_RATE_HZ(100),
        .ACC_W      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .btn_pos    (btn_pos),
        .btn_neg    (btn_neg),
        .tilt_sign  (tilt_sign),
        .tilt_mag   (tilt_mag),
        .move_pos   (move_pos),
        .move_neg   (move_neg),
        .axis_active(axis_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cnt_pos [2];
    int cnt_neg [2];
    int overlap;
    int dt;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (move_pos[i]) cnt_pos[i]++;
            if (move_neg[i]) cnt_neg[i]++;
            if (move_pos[i] && move_neg[i]) overlap++;
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            cnt_pos[i] = 0;
            cnt_neg[i] = 0;
        end
    endtask

    // Cycles until the selected output pulses; -1 if budget expires.
    task automatic next_pulse(input int ax, input bit pos,
                              input int budget, output int d);
        d = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (pos ? move_pos[ax] : move_neg[ax]) begin
                d = k;
                break;
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        overlap   = 0;
        reset     = 1'b1;
        mode      = 2'b00;
        btn_pos   = '0;
        btn_neg   = '0;
        tilt_sign = '0;
        tilt_mag  = '0;
        clr();
        repeat (3) step();
        chk("rst_move_pos", move_pos, 0);
        chk("rst_move_neg", move_neg, 0);
        chk("rst_active", axis_active, 0);
        reset = 1'b0;
        step();

        // button hold, mode 01
        mode = 2'b01;
        step();
        clr();
        btn_pos[0] = 1'b1;
        step();
        chk("btn_first", move_pos[0], 1);
        chk("btn_active", axis_active[0], 1);
        for (int p = 0; p < 3; p++) begin
            next_pulse(0, 1'b1, 15, dt);
            chk("btn_gap", dt, 10);
        end
        repeat (4) step();
        chk("btn_count", cnt_pos[0], 4);
        btn_pos[0] = 1'b0;
        step();
        chk("btn_stop", move_pos[0], 0);
        chk("btn_idle", axis_active[0], 0);
        repeat (12) step();
        chk("btn_count_after", cnt_pos[0], 4);
        chk("btn_quiet", cnt_neg[0] + cnt_pos[1] + cnt_neg[1], 0);

        // both buttons pressed
        clr();
        btn_pos[0] = 1'b1;
        btn_neg[0] = 1'b1;
        repeat (20) step();
        chk("both_pulses", cnt_pos[0] + cnt_neg[0], 0);
        chk("both_active", axis_active[0], 0);
        btn_pos = '0;
        btn_neg = '0;
        step();

        // reset right before a carry pulse
        clr();
        btn_pos[0] = 1'b1;
        step();
        chk("rh_first", move_pos[0], 1);
        repeat (9) step();
        reset = 1'b1;
        step();
        chk("rh_move_pos", move_pos, 0);
        chk("rh_move_neg", move_neg, 0);
        chk("rh_active", axis_active, 0);
        chk("rh_count", cnt_pos[0], 1);
        reset = 1'b0;
        step();
        chk("rh_resume", move_pos[0], 1);
        btn_pos[0] = 1'b0;
        step();

        // mode 01 -> 00 -> 01 with button held
        btn_pos[0] = 1'b1;
        step();
        chk("mt_first", move_pos[0], 1);
        repeat (3) step();
        mode = 2'b00;
        step();
        chk("mt_off_pulse", move_pos[0], 0);
        chk("mt_off_active", axis_active[0], 0);
        clr();
        repeat (12) step();
        chk("mt_off_count", cnt_pos[0], 0);
        mode = 2'b01;
        step();
        chk("mt_back", move_pos[0], 1);
        btn_pos[0] = 1'b0;
        mode = 2'b00;
        step();

        // mode 11: button beats tilt on axis 1
        mode = 2'b11;
        tilt_sign[1] = 1'b1;
        tilt_mag[15:8] = 8'd255;
        btn_neg[1] = 1'b1;
        clr();
        step();
        chk("m11_btn_first", move_neg[1], 1);
        chk("m11_btn_nopos", move_pos[1], 0);
        for (int p = 0; p < 2; p++) begin
            next_pulse(1, 1'b0, 15, dt);
            chk("m11_btn_gap", dt, 10);
        end
        chk("m11_btn_pos_cnt", cnt_pos[1], 0);
        btn_neg[1] = 1'b0;
        clr();
        step();
        chk("m11_tilt_first", move_pos[1], 1);
        next_pulse(1, 1'b1, 20, dt);
        chk("m11_tilt_gap1", dt, 11);
        next_pulse(1, 1'b1, 20, dt);
        chk("m11_tilt_gap2", dt, 10);
        chk("m11_tilt_neg_cnt", cnt_neg[1], 0);
        tilt_mag[15:8] = 8'd0;
        mode = 2'b00;
        step();

        // mode 10: dead-zone edge and rate change on axis 0
        mode = 2'b10;
        tilt_sign[0] = 1'b0;
        tilt_mag[7:0] = 8'd16;
        clr();
        repeat (30) step();
        chk("dz_pulses", cnt_pos[0] + cnt_neg[0], 0);
        chk("dz_active", axis_active[0], 0);
        tilt_mag[7:0] = 8'd17;
        step();
        chk("t17_first", move_neg[0], 1);
        next_pulse(0, 1'b0, 2600, dt);
        chk("t17_gap", dt, 2391);
        repeat (5) step();
        clr();
        tilt_mag[7:0] = 8'd135;
        step();
        chk("t135_no_extra", move_neg[0], 0);
        next_pulse(0, 1'b0, 40, dt);
        chk("t135_gap1", dt, 20);
        next_pulse(0, 1'b0, 40, dt);
        chk("t135_gap2", dt, 20);
        chk("t135_pos_cnt", cnt_pos[0], 0);
        chk("axis1_quiet", cnt_pos[1] + cnt_neg[1], 0);
        chk("overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_pulse_gen.md
# move_pulse_gen

Parametrised movement-pulse generator for the labyrinth ball. It replaces the ad-hoc fixed-rate tick counters and the button/accelerometer OR-ing in the top level with one block. Per axis, it turns push-buttons and signed accelerometer tilt into single-cycle step pulses. Button steps run at a fixed rate; tilt steps run at a rate proportional to tilt beyond a dead-zone. The outputs drive the `Ball` movement inputs directly.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: clock frequency.
- `NUM_AXES`, 2: number of independent axes (0 = X, 1 = Y).
- `MAG_W`, 8: accelerometer magnitude width.
- `DEADZONE`, 16: tilt magnitude at or below which no tilt motion occurs.
- `BTN_RATE_HZ`, 90: step rate while a button is held.
- `MAX_RATE_HZ`, 120: tilt step rate at full-scale magnitude.
- `ACC_W`, 32: phase accumulator width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  2  source select: 00 off, 01 buttons only, 10 tilt only, 11 both (buttons have priority).
- `btn_pos`  in  NUM_AXES  debounced button, positive direction per axis.
- `btn_neg`  in  NUM_AXES  debounced button, negative direction per axis.
- `tilt_sign`  in  NUM_AXES  accelerometer sign bit; 1 = positive.
- `tilt_mag`  in  NUM_AXES*MAG_W  magnitude per axis; axis i occupies bits [i*MAG_W +: MAG_W].
- `move_pos`  out  NUM_AXES  one-cycle step pulse, positive direction.
- `move_neg`  out  NUM_AXES  one-cycle step pulse, negative direction.
- `axis_active`  out  NUM_AXES  level; the axis currently has a non-idle direction.

## Operation
- Each axis has a direction state with values IDLE, POS and NEG. It also has a source flag (BTN or TILT) and an `ACC_W`-bit phase accumulator.
- Requested direction, evaluated every cycle:
  - Button request: `btn_pos` XOR `btn_neg`. When both buttons are pressed, or neither is pressed, there is no button request.
  - Tilt request: exists only when `tilt_mag` > `DEADZONE`. Direction is taken from `tilt_sign`.
  - Mode 01 uses only the button request. Mode 10 uses only the tilt request. Mode 11 uses the button request if one exists, otherwise the tilt request. Mode 00 always yields IDLE.
- Increment:
  - BTN source: `BTN_INC` = round(BTN_RATE_HZ·2^ACC_W / CLK_HZ).
  - TILT source: (tilt_mag − DEADZONE) · `TILT_STEP`, where `TILT_STEP` = round(MAX_RATE_HZ·2^ACC_W / (CLK_HZ·(2^MAG_W − 1 − DEADZONE))).
  - The product saturates at 2^ACC_W − 1.
  - The tilt increment is recomputed every cycle, so the rate tracks the magnitude with no restart.
- Transitions:
  - IDLE→POS/NEG: emit a pulse in that direction immediately and clear the accumulator.
  - Same direction, same source: add the increment each cycle. Emit a pulse on the cycle the addition carries out of `ACC_W` bits. Keep the low bits.
  - Direction change (POS↔NEG) or source change (BTN↔TILT): treat as a new activation. Emit an immediate pulse and clear the accumulator.
  - Request lost: go to IDLE, clear the accumulator, emit no pulse.
- `move_pos[i]` and `move_neg[i]` are never high in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0; all states are IDLE, all accumulators 0.
- Latency: an input change sampled at edge n produces its first pulse at edge n+1.
- Pulse width is exactly 1 cycle.
- Steady-state pulse spacing is ceil(2^ACC_W / inc) cycles, or occasionally one fewer from residual carry.
- Holding a button continuously produces the first pulse, then pulses at BTN_RATE_HZ with no gap anomaly.
- Reset asserted mid-operation: outputs are 0 on the next edge. No pulse is emitted on the edge where reset is sampled high.
- A mode change takes effect on the next edge, under the transition rules above.
- Axes are fully independent; simultaneous pulses on different axes are allowed.

## Structure
- Package `move_pkg`:
  - mode encodings `MODE_OFF`, `MODE_BTN`, `MODE_TILT`, `MODE_BOTH`
  - direction enum `DIR_IDLE`, `DIR_POS`, `DIR_NEG`
  - source enum `SRC_BTN`, `SRC_TILT`
- Sub-module `move_axis`:
  - handles one axis: request resolution, state, accumulator and pulse registers
  - `move_pulse_gen` instantiates it `NUM_AXES` times in a generate loop
- Compute `BTN_INC` and `TILT_STEP` as localparams in `move_pulse_gen` and pass them down.

## Test plan
Bench parameters: CLK_HZ=1000, BTN_RATE_HZ=100, MAX_RATE_HZ=100, MAG_W=8, DEADZONE=16, ACC_W=32.

- Reset, then mode=01, `btn_pos[0]` held for 35 cycles → `move_pos[0]` pulses 1 cycle after the press. Later pulses are spaced 10 cycles apart, 4 pulses in total. Pulses stop the cycle after release. Axis 1 stays silent.
- mode=11, `btn_neg[1]` held while `tilt_mag[1]`=255 with `tilt_sign[1]`=1 → only `move_neg[1]` pulses, at button rate. Releasing the button yields an immediate `move_pos[1]` pulse, then tilt-rate pulses (≈10-cycle spacing).
- mode=10, `tilt_mag[0]`=16 → no pulses. Changing to 17 → immediate pulse, then spacing ≈2390 cycles. Changing to 135 → spacing ≈20 cycles, with no extra pulse at the change.
- Both `btn_pos[0]` and `btn_neg[0]` pressed under mode=01 → no pulses and `axis_active[0]`=0.
- Reset asserted mid-hold → all outputs 0 on the next edge. After reset is released with the button still held, the first pulse appears 1 cycle later.
- With `btn_pos[0]` held, switch mode 01→00→01 → pulses stop, then an immediate pulse follows the return to 01.
